// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the valid/ready register pipeline.
package reg_pipe_pkg;

  // Bits needed to count 0..depth inclusive
  function automatic int occ_width(input int depth);
    return (depth < 32'sd1) ? 32'sd1 : $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/reg_en_rst.sv
// Enabled register with asynchronous active-low reset and synchronous clear,
// both returning the contents to a parameterised value.
module reg_en_rst #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage element: reset and clear win over load, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VALUE;
    end else if (srst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/reg_pipe_vr.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// synchronous flush and a registered occupancy count.
module reg_pipe_vr
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [WIDTH-1:0]             in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [WIDTH-1:0]             out_msg,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int            OW      = occ_width(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1'b1);

  logic [DEPTH-1:0] val_r;
  logic [WIDTH-1:0] msg_r [DEPTH];
  logic [DEPTH-1:0] val_d_s;
  // acc_s[i]: stage i can take a message; acc_s[DEPTH] is the consumer side.
  // xfer_s[i]: a message enters stage i; xfer_s[DEPTH] is the output transfer.
  logic [DEPTH:0]   acc_s;
  logic [DEPTH:0]   xfer_s;
  logic [OW-1:0]    occ_r;
  logic [OW-1:0]    occ_nxt_s;

  // Advance chain, resolved from the output stage back to the input
  always_comb begin
    acc_s        = {(DEPTH + 1){1'b0}};
    xfer_s       = {(DEPTH + 1){1'b0}};
    val_d_s      = {DEPTH{1'b0}};
    acc_s[DEPTH] = out_rdy & ~flush;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      xfer_s[i+1] = val_r[i] & acc_s[i+1] & ~flush;
      acc_s[i]    = ~val_r[i] | xfer_s[i+1];
    end
    xfer_s[0] = in_val & acc_s[0] & ~flush;
    for (int i = 0; i < DEPTH; i++) begin
      val_d_s[i] = xfer_s[i] | (val_r[i] & ~xfer_s[i+1]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] msg_d_s;
    if (i == 0) begin : g_head
      assign msg_d_s = in_msg;
    end else begin : g_body
      assign msg_d_s = msg_r[i-1];
    end

    // Message payload keeps its contents across a flush
    reg_en_rst #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_msg (
      .clk     (clk),
      .reset_n (reset_n),
      .srst    (1'b0),
      .en      (xfer_s[i]),
      .d       (msg_d_s),
      .q       (msg_r[i])
    );

    reg_en_rst #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
    ) u_val (
      .clk     (clk),
      .reset_n (reset_n),
      .srst    (flush),
      .en      (1'b1),
      .d       (val_d_s[i]),
      .q       (val_r[i])
    );
  end

  // Occupancy follows accepted minus delivered messages
  always_comb begin
    occ_nxt_s = occ_r;
    case ({xfer_s[0], xfer_s[DEPTH]})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Occupancy register, cleared by reset or flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_r <= {OW{1'b0}};
    end else if (flush) begin
      occ_r <= {OW{1'b0}};
    end else begin
      occ_r <= occ_nxt_s;
    end
  end

  assign in_rdy    = acc_s[0] & ~flush;
  assign out_val   = val_r[DEPTH-1] & ~flush;
  assign out_msg   = msg_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_reg_pipe_vr.sv
// Self-checking bench for reg_pipe_vr: directed test-plan scenarios followed
// by random traffic, scored against a message-queue timing model.
module tb_reg_pipe_vr;

  localparam int DEPTH = 3;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_val;
  logic             in_rdy;
  logic [WIDTH-1:0] in_msg;
  logic             out_val;
  logic             out_rdy;
  logic [WIDTH-1:0] out_msg;
  logic [1:0]       occupancy;

  reg_pipe_vr #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: FIFO of messages with the edge on which each was accepted.
  // A message reaches the output DEPTH-1 edges after acceptance, but never
  // before the edge on which its predecessor left.
  typedef struct {
    logic [WIDTH-1:0] msg;
    int               acc;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   last_dep;
  int   n_checks;
  int   n_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int head_ready();
    int r;
    r = q[0].acc + DEPTH - 1;
    if (last_dep > r) r = last_dep;
    return r;
  endfunction

  task automatic cycle(input logic v, input logic [WIDTH-1:0] m, input logic r, input logic f);
    logic e_rdy;
    logic e_val;
    @(negedge clk);
    in_val  = v;
    in_msg  = m;
    out_rdy = r;
    flush   = f;
    #1;
    e_rdy = !f && ((q.size() < DEPTH) || r);
    e_val = !f && (q.size() > 0) && (cyc >= head_ready());
    chk("in_rdy", 32'(in_rdy), 32'(e_rdy));
    chk("out_val", 32'(out_val), 32'(e_val));
    if (e_val) chk("out_msg", 32'(out_msg), 32'(q[0].msg));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (f) begin
      q.delete();
    end else begin
      if (e_val && r) begin
        void'(q.pop_front());
        last_dep = cyc + 1;
      end
      if (v && e_rdy) q.push_back('{m, cyc + 1});
    end
    @(posedge clk);
    cyc++;
  endtask

  // Reset asserted between edges; outputs must react without a clock edge
  task automatic mid_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    flush   = 1'b0;
    #1;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_msg", 32'(out_msg), 32'h00);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    q.delete();
    last_dep = 0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    cyc      = 0;
    last_dep = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    in_val   = 1'b0;
    in_msg   = 8'h00;
    out_rdy  = 1'b0;
    #1;
    chk("init_out_val", 32'(out_val), 32'd0);
    chk("init_out_msg", 32'(out_msg), 32'h00);
    chk("init_in_rdy", 32'(in_rdy), 32'd1);
    chk("init_occupancy", 32'(occupancy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single transfer: accepted on edge 1, visible after edge 3 for one cycle
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure, then same-cycle drain and accept
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h13, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse
    cycle(1'b1, 8'h20, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with two entries in flight, offering a message during flush
    repeat (2) cycle(1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 8'h41, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Refill and reset mid-operation
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    mid_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
      end else begin
        cycle(($urandom_range(0, 9) < 7), 8'($urandom),
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
